// File: rtl/afe_store_align.sv
// afe_store_align
// Store-side lane aligner between the load/store unit and the data-memory
// request port. A byte, halfword or word store at any byte address becomes
// one or two word-aligned write beats with big-endian byte enables. When a
// store crosses a word boundary it is split into two beats, or it becomes a
// single fault beat if splitting is disabled.
//
// State table:
//   ST_IDLE  | output register empty, or holding the last beat of a request
//   ST_SPLIT | output register holds beat0 (LAST=0); beat1 waits in r_b1_*
//
// Ports:
//   iCLOCK, iRESET_SYNC   clock, synchronous active-high reset
//   iFLUSH                drop the held beat and any pending second beat
//   iPREV_VALID/oPREV_BUSY  request handshake from the load/store unit
//   iPREV_SIZE/ADDR/DATA  store size (0 byte, 1 half, 2 word, 3 reserved),
//                         byte address, right-justified data
//   oNEXT_VALID/iNEXT_BUSY  beat handshake towards memory
//   oNEXT_ADDR/DATA/MASK  word-aligned address, lane-placed data, byte enables
//                         (mask bit3 = byte offset 0 = data[31:24])
//   oNEXT_LAST/FAULT      final beat of the request, faulting request
module afe_store_align #(
    parameter int P_MISALIGN_SPLIT = 1
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iFLUSH,
    input  logic        iPREV_VALID,
    output logic        oPREV_BUSY,
    input  logic [1:0]  iPREV_SIZE,
    input  logic [31:0] iPREV_ADDR,
    input  logic [31:0] iPREV_DATA,
    output logic        oNEXT_VALID,
    input  logic        iNEXT_BUSY,
    output logic [31:0] oNEXT_ADDR,
    output logic [31:0] oNEXT_DATA,
    output logic [3:0]  oNEXT_MASK,
    output logic        oNEXT_LAST,
    output logic        oNEXT_FAULT
);

    localparam bit LP_SPLIT_EN = (P_MISALIGN_SPLIT != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_valid;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_mask;
    logic        r_last;
    logic        r_fault;
    logic [31:0] r_b1_addr;
    logic [31:0] r_b1_data;
    logic [3:0]  r_b1_mask;

    logic [1:0]  w_off;
    logic [31:0] w_left;
    logic [3:0]  w_mask_left;
    logic [63:0] w_wide;
    logic [7:0]  w_wmask;
    logic        w_split;
    logic        w_fault;
    logic [31:0] w_base;
    logic        w_prev_busy;
    logic        w_accept;
    logic        w_consume;

    assign w_off = iPREV_ADDR[1:0];

    // Left-justify the store so that offset 0 lines up with data[31:24].
    always_comb begin
        w_left      = iPREV_DATA;
        w_mask_left = 4'b1111;
        case (iPREV_SIZE)
            2'd0: begin
                w_left      = {iPREV_DATA[7:0], 24'h0};
                w_mask_left = 4'b1000;
            end
            2'd1: begin
                w_left      = {iPREV_DATA[15:0], 16'h0};
                w_mask_left = 4'b1100;
            end
            default: begin
                w_left      = iPREV_DATA;
                w_mask_left = 4'b1111;
            end
        endcase
    end

    // Shifting across a two-word window: whatever spills into the low word
    // belongs to the following word address.
    assign w_wide  = {w_left, 32'h0} >> {w_off, 3'b000};
    assign w_wmask = {w_mask_left, 4'h0} >> w_off;
    assign w_split = |w_wmask[3:0];
    assign w_fault = (iPREV_SIZE == 2'd3) | (w_split & ~LP_SPLIT_EN);
    assign w_base  = {iPREV_ADDR[31:2], 2'b00};

    assign w_prev_busy = iNEXT_BUSY | (r_state == ST_SPLIT);
    assign w_accept    = iPREV_VALID & ~w_prev_busy & ~iFLUSH;
    assign w_consume   = r_valid & ~iNEXT_BUSY;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_state   <= ST_IDLE;
            r_valid   <= 1'b0;
            r_addr    <= 32'h0;
            r_data    <= 32'h0;
            r_mask    <= 4'h0;
            r_last    <= 1'b0;
            r_fault   <= 1'b0;
            r_b1_addr <= 32'h0;
            r_b1_data <= 32'h0;
            r_b1_mask <= 4'h0;
        end else if (iFLUSH) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Accept implies the output slot is empty or being
                    // consumed, so loading here never overwrites a live beat.
                    if (w_accept) begin
                        r_valid <= 1'b1;
                        r_addr  <= w_base;
                        if (w_fault) begin
                            r_data  <= 32'h0;
                            r_mask  <= 4'h0;
                            r_last  <= 1'b1;
                            r_fault <= 1'b1;
                        end else begin
                            r_data  <= w_wide[63:32];
                            r_mask  <= w_wmask[7:4];
                            r_last  <= ~w_split;
                            r_fault <= 1'b0;
                            if (w_split) begin
                                r_state   <= ST_SPLIT;
                                r_b1_addr <= w_base + 32'd4;
                                r_b1_data <= w_wide[31:0];
                                r_b1_mask <= w_wmask[3:0];
                            end
                        end
                    end else if (w_consume) begin
                        r_valid <= 1'b0;
                    end
                end
                ST_SPLIT: begin
                    if (w_consume) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b1;
                        r_addr  <= r_b1_addr;
                        r_data  <= r_b1_data;
                        r_mask  <= r_b1_mask;
                        r_last  <= 1'b1;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign oPREV_BUSY  = w_prev_busy;
    assign oNEXT_VALID = r_valid;
    assign oNEXT_ADDR  = r_addr;
    assign oNEXT_DATA  = r_data;
    assign oNEXT_MASK  = r_mask;
    assign oNEXT_LAST  = r_last;
    assign oNEXT_FAULT = r_fault;

endmodule

// File: tb/tb_afe_store_align.sv
// Bench for afe_store_align: directed scenarios followed by random traffic,
// checked against a byte-level model of where each stored byte must land.
module tb_afe_store_align;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        last;
        logic        fault;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        pv;
    logic [1:0]  psize;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic        nbusy;

    logic        pbusy,  nvalid,  nlast,  nfault;
    logic [31:0] naddr,  ndata;
    logic [3:0]  nmask;
    logic        pbusy_ns, nvalid_ns, nlast_ns, nfault_ns;
    logic [31:0] naddr_ns, ndata_ns;
    logic [3:0]  nmask_ns;

    int n_checks = 0;
    int n_errors = 0;
    beat_t q[$];

    afe_store_align #(.P_MISALIGN_SPLIT(1)) dut (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(flush),
        .iPREV_VALID(pv), .oPREV_BUSY(pbusy), .iPREV_SIZE(psize),
        .iPREV_ADDR(paddr), .iPREV_DATA(pdata),
        .oNEXT_VALID(nvalid), .iNEXT_BUSY(nbusy), .oNEXT_ADDR(naddr),
        .oNEXT_DATA(ndata), .oNEXT_MASK(nmask), .oNEXT_LAST(nlast),
        .oNEXT_FAULT(nfault)
    );

    afe_store_align #(.P_MISALIGN_SPLIT(0)) dut_ns (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(flush),
        .iPREV_VALID(pv), .oPREV_BUSY(pbusy_ns), .iPREV_SIZE(psize),
        .iPREV_ADDR(paddr), .iPREV_DATA(pdata),
        .oNEXT_VALID(nvalid_ns), .iNEXT_BUSY(nbusy), .oNEXT_ADDR(naddr_ns),
        .oNEXT_DATA(ndata_ns), .oNEXT_MASK(nmask_ns), .oNEXT_LAST(nlast_ns),
        .oNEXT_FAULT(nfault_ns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Each stored byte goes to address a+k, most significant byte first;
    // bytes are then grouped by the word they fall into.
    function automatic void model(input logic [1:0] sz, input logic [31:0] a,
                                  input logic [31:0] d, input bit split_en,
                                  output beat_t b0, output beat_t b1, output int n);
        int   nb;
        int   pos;
        bit   crosses;
        logic [7:0]  bval;
        logic [31:0] base;
        nb      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base    = {a[31:2], 2'b00};
        b0      = '{addr: base, data: 32'h0, mask: 4'h0, last: 1'b1, fault: 1'b0};
        b1      = '{addr: base + 32'd4, data: 32'h0, mask: 4'h0, last: 1'b1, fault: 1'b0};
        crosses = 1'b0;
        for (int k = 0; k < nb; k++) begin
            bval = 8'(d >> (8 * (nb - 1 - k)));
            pos  = int'(a[1:0]) + k;
            if (pos < 4) begin
                b0.mask[3 - pos] = 1'b1;
                b0.data[(3 - pos) * 8 +: 8] = bval;
            end else begin
                crosses = 1'b1;
                b1.mask[7 - pos] = 1'b1;
                b1.data[(7 - pos) * 8 +: 8] = bval;
            end
        end
        if (sz == 2'd3 || (crosses && !split_en)) begin
            b0 = '{addr: base, data: 32'h0, mask: 4'h0, last: 1'b1, fault: 1'b1};
            n  = 1;
        end else if (crosses) begin
            b0.last = 1'b0;
            n = 2;
        end else begin
            n = 1;
        end
    endfunction

    // Called just after a falling edge: checks presented outputs, drives
    // this cycle's inputs, checks busy, advances the model, waits one cycle.
    task automatic do_cycle(input bit v, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] d, input bit busy, input bit fl);
        bit    exp_busy;
        beat_t b0, b1;
        int    n;
        if (q.size() > 0) begin
            chk("valid", 32'(nvalid), 32'h1);
            chk("addr",  naddr, q[0].addr);
            chk("data",  ndata, q[0].data);
            chk("mask",  32'(nmask),  32'(q[0].mask));
            chk("last",  32'(nlast),  32'(q[0].last));
            chk("fault", 32'(nfault), 32'(q[0].fault));
        end else begin
            chk("idle_valid", 32'(nvalid), 32'h0);
        end
        pv = v; psize = sz; paddr = a; pdata = d; nbusy = busy; flush = fl;
        #1;
        exp_busy = busy | (q.size() > 0 && !q[0].last);
        chk("prev_busy", 32'(pbusy), 32'(exp_busy));
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && !busy) void'(q.pop_front());
            if (v && !exp_busy) begin
                model(sz, a, d, 1'b1, b0, b1, n);
                q.push_back(b0);
                if (n == 2) q.push_back(b1);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit busy);
        do_cycle(1'b0, 2'd0, 32'h0, 32'h0, busy, 1'b0);
    endtask

    task automatic expect_lit(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m, input bit last, input bit fault);
        chk({tag, "_valid"}, 32'(nvalid), 32'h1);
        chk({tag, "_addr"},  naddr, a);
        chk({tag, "_data"},  ndata, d);
        chk({tag, "_mask"},  32'(nmask),  32'(m));
        chk({tag, "_last"},  32'(nlast),  32'(last));
        chk({tag, "_fault"}, 32'(nfault), 32'(fault));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(nvalid), 32'h0);
        chk({tag, "_addr"},  naddr, 32'h0);
        chk({tag, "_data"},  ndata, 32'h0);
        chk({tag, "_mask"},  32'(nmask),  32'h0);
        chk({tag, "_last"},  32'(nlast),  32'h0);
        chk({tag, "_fault"}, 32'(nfault), 32'h0);
        chk({tag, "_busy"},  32'(pbusy),  32'(nbusy));
    endtask

    initial begin
        logic [1:0]  rsz;
        logic [31:0] raddr;

        rst = 1'b1; flush = 1'b0; pv = 1'b0; psize = 2'd0;
        paddr = 32'h0; pdata = 32'h0; nbusy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // 1: aligned word
        do_cycle(1'b1, 2'd2, 32'h100, 32'h11223344, 1'b0, 1'b0);
        expect_lit("t1", 32'h100, 32'h11223344, 4'b1111, 1'b1, 1'b0);
        idle(1'b0);

        // 2: bytes at offsets 3 and 1, back to back
        do_cycle(1'b1, 2'd0, 32'h103, 32'h000000AB, 1'b0, 1'b0);
        expect_lit("t2a", 32'h100, 32'h000000AB, 4'b0001, 1'b1, 1'b0);
        do_cycle(1'b1, 2'd0, 32'h101, 32'h000000AB, 1'b0, 1'b0);
        expect_lit("t2b", 32'h100, 32'h00AB0000, 4'b0100, 1'b1, 1'b0);
        idle(1'b0);

        // 3: halfword crossing a word boundary
        do_cycle(1'b1, 2'd1, 32'h203, 32'h0000BEEF, 1'b0, 1'b0);
        expect_lit("t3b0", 32'h200, 32'h000000BE, 4'b0001, 1'b0, 1'b0);
        chk("t3_busy_split", 32'(pbusy), 32'h1);
        chk("t3ns_valid", 32'(nvalid_ns), 32'h1);
        chk("t3ns_addr",  naddr_ns, 32'h200);
        chk("t3ns_data",  ndata_ns, 32'h0);
        chk("t3ns_mask",  32'(nmask_ns),  32'h0);
        chk("t3ns_last",  32'(nlast_ns),  32'h1);
        chk("t3ns_fault", 32'(nfault_ns), 32'h1);
        chk("t3ns_busy",  32'(pbusy_ns),  32'h0);
        idle(1'b0);
        expect_lit("t3b1", 32'h204, 32'hEF000000, 4'b1000, 1'b1, 1'b0);
        idle(1'b0);

        // 4: misaligned word with a 3-cycle stall on beat0
        do_cycle(1'b1, 2'd2, 32'h301, 32'h11223344, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_lit("t4hold", 32'h300, 32'h00112233, 4'b0111, 1'b0, 1'b0);
            idle(1'b1);
        end
        expect_lit("t4hold", 32'h300, 32'h00112233, 4'b0111, 1'b0, 1'b0);
        idle(1'b0);
        expect_lit("t4b1", 32'h304, 32'h44000000, 4'b1000, 1'b1, 1'b0);
        idle(1'b0);
        do_cycle(1'b1, 2'd2, 32'hFFFFFFFE, 32'hA1B2C3D4, 1'b0, 1'b0);
        expect_lit("t4wrap0", 32'hFFFFFFFC, 32'h0000A1B2, 4'b0011, 1'b0, 1'b0);
        idle(1'b0);
        expect_lit("t4wrap1", 32'h00000000, 32'hC3D40000, 4'b1100, 1'b1, 1'b0);
        idle(1'b0);

        // 5: flush on beat0 of a split, request in flush cycle ignored
        do_cycle(1'b1, 2'd1, 32'h203, 32'h0000BEEF, 1'b0, 1'b0);
        do_cycle(1'b1, 2'd2, 32'h500, 32'h55555555, 1'b0, 1'b1);
        chk("t5_flush_valid", 32'(nvalid), 32'h0);
        do_cycle(1'b1, 2'd2, 32'h600, 32'h66778899, 1'b0, 1'b0);
        expect_lit("t5_after", 32'h600, 32'h66778899, 4'b1111, 1'b1, 1'b0);
        idle(1'b0);
        do_cycle(1'b1, 2'd1, 32'h203, 32'h0000BEEF, 1'b0, 1'b0);
        pv = 1'b1; rst = 1'b1;
        @(negedge clk);
        check_reset_state("t5_reset");
        rst = 1'b0; pv = 1'b0;
        q.delete();

        // 6: reserved size, then four back-to-back aligned words
        do_cycle(1'b1, 2'd3, 32'h400, 32'hDEADBEEF, 1'b0, 1'b0);
        expect_lit("t6fault", 32'h400, 32'h0, 4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 2'd2, 32'h700 + 32'(4 * i), 32'h01020300 + 32'(i), 1'b0, 1'b0);
            chk("t6_valid", 32'(nvalid), 32'h1);
            chk("t6_busy", 32'(pbusy), 32'h0);
        end
        idle(1'b0);
        idle(1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rsz   = 2'($urandom_range(0, 3));
            raddr = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
            do_cycle($urandom_range(0, 2) != 0, rsz, raddr, $urandom,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
        end
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
